uart_tx_scheduler: RTL

Message-level scheduler that shares the single UART Transmitter between NREQ byte-stream requesters (e.g. result formatter, debug echo, status reporter). It arbitrates round-robin per message, fetches bytes from the granted requester, drives the Transmitter's start/data inputs and paces on its `tx_done`. It sits between the requester logic and the Transmitter; the baud-rate generator and Transmitter are unchanged.

---
 rtl/uart_tx_scheduler_if.sv | 26 ++
 rtl/uart_tx_scheduler.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler_if.sv
// Requester byte lanes plus the Transmitter start/data/done handshake seen by uart_tx_scheduler.
// master = scheduler side, slave = requesters and Transmitter side.
interface uart_tx_scheduler_if #(
    parameter int NREQ  = 2,
    parameter int DBITS = 8
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DBITS-1:0] req_data;
    logic [NREQ-1:0]       req_last;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic                  tx_start;
    logic [DBITS-1:0]      tx_data;
    logic                  tx_done;

    modport master (
        input  req_valid, req_data, req_last, tx_done,
        output req_ready, grant, busy, tx_start, tx_data
    );

    modport slave (
        output req_valid, req_data, req_last, tx_done,
        input  req_ready, grant, busy, tx_start, tx_data
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin, message-granular sharing of one UART Transmitter among NREQ byte streams.
// Define UART_TX_SCHED_CRLF_EN to append CR (13) and LF (10) after every message.
module uart_tx_scheduler #(
    parameter int NREQ  = 2,
    parameter int DBITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    uart_tx_scheduler_if.master bus
);
    localparam int IW = $clog2(NREQ);

`ifdef UART_TX_SCHED_CRLF_EN
    typedef enum logic [2:0] {IDLE, FETCH, SEND, WAIT, CR, LF} state_t;
    typedef enum logic [1:0] {SEQ_DATA, SEQ_CR, SEQ_LF} seq_t;
    seq_t seq_reg, seq_next;
`else
    typedef enum logic [1:0] {IDLE, FETCH, SEND, WAIT} state_t;
`endif

    state_t           state_reg, state_next;
    logic [NREQ-1:0]  grant_reg, grant_next;
    logic [IW-1:0]    grant_idx_reg, grant_idx_next;
    logic [IW-1:0]    rr_ptr_reg, rr_ptr_next;
    logic [DBITS-1:0] tx_data_reg, tx_data_next;
    logic             last_reg, last_next;
    logic [NREQ-1:0]  req_ready;
    logic             tx_start;
    logic             msg_end;
    logic [NREQ-1:0]  rot_valid;
    logic [NREQ-1:0]  pick_onehot;
    logic [IW-1:0]    rot_k;
    logic [IW-1:0]    pick_idx;
    logic [IW:0]      pick_sum;

    // Rotate requests so rr_ptr sits at bit 0, then take the lowest set bit.
    always_comb begin
        rot_valid = NREQ'({bus.req_valid, bus.req_valid} >> rr_ptr_reg);
        rot_k     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot_valid[k]) rot_k = IW'(k);
        end
    end

    assign pick_sum = {1'b0, rr_ptr_reg} + {1'b0, rot_k};
    assign pick_idx = (pick_sum >= (IW+1)'(NREQ)) ? IW'(pick_sum - (IW+1)'(NREQ))
                                                 : pick_sum[IW-1:0];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
        assign pick_onehot[gi] = (pick_idx == IW'(gi));
    end

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        grant_idx_next = grant_idx_reg;
        rr_ptr_next    = rr_ptr_reg;
        tx_data_next   = tx_data_reg;
        last_next      = last_reg;
`ifdef UART_TX_SCHED_CRLF_EN
        seq_next       = seq_reg;
`endif
        req_ready      = '0;
        tx_start       = 1'b0;
        msg_end        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (|bus.req_valid) begin
                    grant_next     = pick_onehot;
                    grant_idx_next = pick_idx;
                    state_next     = FETCH;
                end
            end
            FETCH: begin
                req_ready = grant_reg & bus.req_valid;
                if (|req_ready) begin
                    tx_data_next = bus.req_data[grant_idx_reg*DBITS +: DBITS];
                    last_next    = bus.req_last[grant_idx_reg];
`ifdef UART_TX_SCHED_CRLF_EN
                    seq_next     = SEQ_DATA;
`endif
                    state_next   = SEND;
                end
            end
            SEND: begin
                tx_start   = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (bus.tx_done) begin
`ifdef UART_TX_SCHED_CRLF_EN
                    if (seq_reg == SEQ_CR)      state_next = LF;
                    else if (seq_reg == SEQ_LF) msg_end    = 1'b1;
                    else if (last_reg)          state_next = CR;
                    else                        state_next = FETCH;
`else
                    if (last_reg) msg_end    = 1'b1;
                    else          state_next = FETCH;
`endif
                end
            end
`ifdef UART_TX_SCHED_CRLF_EN
            CR: begin
                tx_data_next = DBITS'(13);
                seq_next     = SEQ_CR;
                state_next   = SEND;
            end
            LF: begin
                tx_data_next = DBITS'(10);
                seq_next     = SEQ_LF;
                state_next   = SEND;
            end
`endif
            default: state_next = IDLE;
        endcase

        // Next search starts just past the requester that owned this message.
        if (msg_end) begin
            grant_next  = '0;
            rr_ptr_next = (grant_idx_reg == IW'(NREQ - 1)) ? '0 : grant_idx_reg + IW'(1);
            state_next  = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            grant_idx_reg <= '0;
            rr_ptr_reg    <= '0;
            tx_data_reg   <= '0;
            last_reg      <= 1'b0;
`ifdef UART_TX_SCHED_CRLF_EN
            seq_reg       <= SEQ_DATA;
`endif
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            grant_idx_reg <= grant_idx_next;
            rr_ptr_reg    <= rr_ptr_next;
            tx_data_reg   <= tx_data_next;
            last_reg      <= last_next;
`ifdef UART_TX_SCHED_CRLF_EN
            seq_reg       <= seq_next;
`endif
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.grant     = grant_reg;
    assign bus.busy      = (state_reg != IDLE);
    assign bus.tx_start  = tx_start;
    assign bus.tx_data   = tx_data_reg;
endmodule
